handshake_cond_br_buffered: RTL

//  Downstream consumer of a handshake integer comparator. Takes the 1-bit compare

---
 rtl/handshake_cond_br_buffered_pkg.sv | 13 +
 rtl/handshake_fifo_1b.sv | 67 ++++++
 rtl/handshake_cond_br_buffered.sv | 89 ++++++++
 3 files changed

// File: rtl/handshake_cond_br_buffered_pkg.sv
// Shared types and default sizes for the buffered conditional branch.
package handshake_cond_br_buffered_pkg;

    // Which successor the token in the output slot is headed for.
    typedef enum logic {
        DEST_FALSE = 1'b0,
        DEST_TRUE  = 1'b1
    } dest_e;

    localparam int DEFAULT_DATA_TYPE = 32;
    localparam int DEFAULT_DEPTH     = 4;

endpackage

// File: rtl/handshake_fifo_1b.sv
// Small valid/ready queue of 1-bit control tokens. Explicit pointer wrap lets
// DEPTH be any value >= 2. A pushed token shows up at the head one cycle later.
module handshake_fifo_1b #(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic ins,
    input  logic ins_valid,
    output logic ins_ready,
    output logic outs,
    output logic outs_valid,
    input  logic outs_ready
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push;
    logic             pop;

    assign ins_ready  = (count_q != CW'(DEPTH));
    assign outs_valid = (count_q != '0);
    assign outs       = mem_q[rd_ptr_q];
    assign push       = ins_valid & ins_ready;
    assign pop        = outs_valid & outs_ready;

    // Next-state for storage, pointers and occupancy from this cycle's push/pop.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            mem_d[wr_ptr_q] = ins;
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers; active-low reset empties the queue.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/handshake_cond_br_buffered.sv
// Conditional branch: pairs each data token with a queued condition and steers
// it through a one-slot output register to the true or false successor.
module handshake_cond_br_buffered
    import handshake_cond_br_buffered_pkg::*;
#(
    parameter int DATA_TYPE = DEFAULT_DATA_TYPE,
    parameter int DEPTH     = DEFAULT_DEPTH
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 condition,
    input  logic                 condition_valid,
    output logic                 condition_ready,
    input  logic [DATA_TYPE-1:0] data,
    input  logic                 data_valid,
    output logic                 data_ready,
    output logic [DATA_TYPE-1:0] trueOut,
    output logic                 trueOut_valid,
    input  logic                 trueOut_ready,
    output logic [DATA_TYPE-1:0] falseOut,
    output logic                 falseOut_valid,
    input  logic                 falseOut_ready
);

    logic                 head;
    logic                 head_valid;
    logic                 drain;
    logic                 fire;

    logic                 out_full_q, out_full_d;
    dest_e                out_dest_q, out_dest_d;
    logic [DATA_TYPE-1:0] out_data_q, out_data_d;

    handshake_fifo_1b #(
        .DEPTH (DEPTH)
    ) u_cond_fifo (
        .clk        (clk),
        .rst        (rst),
        .ins        (condition),
        .ins_valid  (condition_valid),
        .ins_ready  (condition_ready),
        .outs       (head),
        .outs_valid (head_valid),
        .outs_ready (fire)
    );

    // The slot empties when the successor it targets takes the token; the
    // other successor's ready is irrelevant.
    assign drain = out_full_q &
                   ((out_dest_q == DEST_TRUE) ? trueOut_ready : falseOut_ready);

    // Data is only accepted once its condition is at the FIFO head and the slot
    // is free or emptying this cycle, which keeps one token per cycle flowing.
    assign data_ready = head_valid & (~out_full_q | drain);
    assign fire       = data_valid & data_ready;

    assign trueOut        = out_data_q;
    assign falseOut       = out_data_q;
    assign trueOut_valid  = out_full_q & (out_dest_q == DEST_TRUE);
    assign falseOut_valid = out_full_q & (out_dest_q == DEST_FALSE);

    // Output slot next-state: a fire (re)loads, a drain alone empties.
    always_comb begin
        out_full_d = out_full_q;
        out_dest_d = out_dest_q;
        out_data_d = out_data_q;
        if (fire) begin
            out_full_d = 1'b1;
            out_dest_d = dest_e'(head);
            out_data_d = data;
        end else if (drain) begin
            out_full_d = 1'b0;
        end
    end

    // Output slot registers; reset drops any held token.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_full_q <= 1'b0;
            out_dest_q <= DEST_FALSE;
            out_data_q <= '0;
        end else begin
            out_full_q <= out_full_d;
            out_dest_q <= out_dest_d;
            out_data_q <= out_data_d;
        end
    end

endmodule
